// File: rtl/counter_seq_arbiter_if.sv
// Bundle between requesters, the shared 4-bit counter and counter_seq_arbiter.
// master = requester/counter side, slave = arbiter side.
interface counter_seq_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_start;
  logic [4*NREQ-1:0] req_end;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              ctr_load;
  logic [3:0]        ctr_load_val;
  logic              ctr_enable;
  logic [3:0]        ctr_count_val;

  modport master (
    output req, req_start, req_end, ctr_count_val,
    input  gnt, done, busy, ctr_load, ctr_load_val, ctr_enable
  );

  modport slave (
    input  req, req_start, req_end, ctr_count_val,
    output gnt, done, busy, ctr_load, ctr_load_val, ctr_enable
  );
endinterface

// File: rtl/counter_seq_arbiter.sv
// Round-robin sharing of one load/enable up-counter among NREQ requesters.
// Define CSA_BACK2BACK_EN to re-arbitrate in DONE and skip the idle cycle.
module counter_seq_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_seq_arbiter_if.slave bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   start_q;
  logic [CW-1:0]   end_q;

  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] cand;
  logic [PW-1:0]   owner_nxt;
  logic [PW-1:0]   pick;
  logic            found;
  logic [CW-1:0]   pick_start;
  logic [CW-1:0]   pick_end;
  int unsigned     idx;

  assign owner_oh  = NREQ'(1) << owner;
  assign owner_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

  // Cyclic first-set scan from rr_ptr; the finishing owner is masked out in DONE.
  always_comb begin
    cand  = bus.req & ((state == DONE) ? ~owner_oh : '1);
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && cand[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign pick_start = bus.req_start[CW*32'(pick) +: CW];
  assign pick_end   = bus.req_end[CW*32'(pick) +: CW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner   <= pick;
            start_q <= pick_start;
            end_q   <= pick_end;
            state   <= LOAD;
          end
        end
        LOAD: state <= COUNT;
        COUNT: begin
          if (bus.ctr_count_val == end_q) begin
            state  <= DONE;
            rr_ptr <= owner_nxt;
          end else if (!bus.req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end
        end
        DONE: begin
`ifdef CSA_BACK2BACK_EN
          if (found) begin
            owner   <= pick;
            start_q <= pick_start;
            end_q   <= pick_end;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; enable also gates on the live count and req.
  assign bus.gnt          = (state == LOAD || state == COUNT) ? owner_oh : '0;
  assign bus.done         = (state == DONE) ? owner_oh : '0;
  assign bus.busy         = (state != IDLE);
  assign bus.ctr_load     = (state == LOAD);
  assign bus.ctr_load_val = (state == LOAD) ? start_q : '0;
  assign bus.ctr_enable   = (state == COUNT) && (bus.ctr_count_val != end_q) && bus.req[owner];
endmodule
